// File: rtl/sdram_burst_arb_if.sv
// Bus bundle between fifo_ctrl, the burst arbiter and the SDRAM command/data core.
// The arbiter connects through the slave modport; the environment drives through master.
interface sdram_burst_arb_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10
);
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic [LEN_W-1:0]  br_length;
    logic              wr_ack;
    logic              rd_ack;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              core_wr_beat;
    logic              core_rd_beat;
    logic              wr_fifo_rd_en;
    logic              rd_fifo_wr_en;
    logic              busy;
    logic              err_timeout;

    modport slave (
        input  wr_req, rd_req, sdram_wr_addr, sdram_rd_addr, br_length,
        input  cmd_ready, core_wr_beat, core_rd_beat,
        output wr_ack, rd_ack, cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_fifo_rd_en, rd_fifo_wr_en, busy, err_timeout
    );

    modport master (
        output wr_req, rd_req, sdram_wr_addr, sdram_rd_addr, br_length,
        output cmd_ready, core_wr_beat, core_rd_beat,
        input  wr_ack, rd_ack, cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_fifo_rd_en, rd_fifo_wr_en, busy, err_timeout
    );
endinterface

// File: rtl/sdram_burst_arb.sv
// Round-robin write/read burst arbiter between fifo_ctrl and the SDRAM core.
// Define BURST_TIMEOUT_EN to abort a burst after TIMEOUT cycles without a handshake or beat.
module sdram_burst_arb #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 10,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             rst,
    sdram_burst_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WR_CMD, WR_BURST, RD_CMD, RD_BURST, GAP} state_t;

    localparam int                GAP_LEN  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int                GAP_W    = $clog2(GAP_LEN + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_LEN - 1);

    state_t            state;
    logic              last_wr;
    logic [LEN_W-1:0]  beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              cmd_valid_q;
    logic              cmd_write_q;
    logic              wr_ack_q;
    logic              rd_ack_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [LEN_W-1:0]  cmd_len_q;

    logic len_ok;
    logic wr_valid;
    logic rd_valid;
    logic grant_wr;
    logic handshake;
    logic wr_beat;
    logic rd_beat;
    logic last_beat;
    logic stall_hit;

    // Zero-length requests are never granted; on contention the side not served last wins.
    assign len_ok    = (bus.br_length != '0);
    assign wr_valid  = bus.wr_req & len_ok;
    assign rd_valid  = bus.rd_req & len_ok;
    assign grant_wr  = wr_valid & (~rd_valid | ~last_wr);
    assign handshake = cmd_valid_q & bus.cmd_ready;
    assign wr_beat   = (state == WR_BURST) & bus.core_wr_beat;
    assign rd_beat   = (state == RD_BURST) & bus.core_rd_beat;
    assign last_beat = (beat_cnt == cmd_len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_wr     <= 1'b0;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_valid | rd_valid) begin
                        state       <= grant_wr ? WR_CMD : RD_CMD;
                        last_wr     <= grant_wr;
                        cmd_addr_q  <= grant_wr ? bus.sdram_wr_addr : bus.sdram_rd_addr;
                        cmd_len_q   <= bus.br_length;
                        cmd_write_q <= grant_wr;
                        cmd_valid_q <= 1'b1;
                        wr_ack_q    <= grant_wr;
                        rd_ack_q    <= ~grant_wr;
                    end
                end
                WR_CMD, RD_CMD: begin
                    if (handshake) begin
                        state       <= (state == WR_CMD) ? WR_BURST : RD_BURST;
                        cmd_valid_q <= 1'b0;
                        beat_cnt    <= '0;
                    end else if (stall_hit) begin
                        state       <= GAP;
                        gap_cnt     <= '0;
                        cmd_valid_q <= 1'b0;
                        wr_ack_q    <= 1'b0;
                        rd_ack_q    <= 1'b0;
                    end
                end
                WR_BURST, RD_BURST: begin
                    // Dropping the ack on the last beat gives fifo_ctrl exactly one falling edge.
                    if (wr_beat | rd_beat) begin
                        if (last_beat) begin
                            state    <= GAP;
                            gap_cnt  <= '0;
                            wr_ack_q <= 1'b0;
                            rd_ack_q <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end else if (stall_hit) begin
                        state    <= GAP;
                        gap_cnt  <= '0;
                        wr_ack_q <= 1'b0;
                        rd_ack_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BURST_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              err_q;
    logic              waiting;

    assign waiting   = (state == WR_CMD) | (state == RD_CMD) | (state == WR_BURST) | (state == RD_BURST);
    assign stall_hit = waiting & ~handshake & ~wr_beat & ~rd_beat & (idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Counts consecutive cycles without progress while a burst is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= stall_hit;
            if (!waiting || handshake || wr_beat || rd_beat || stall_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign stall_hit       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.wr_ack        = wr_ack_q;
    assign bus.rd_ack        = rd_ack_q;
    assign bus.cmd_valid     = cmd_valid_q;
    assign bus.cmd_write     = cmd_write_q;
    assign bus.cmd_addr      = cmd_addr_q;
    assign bus.cmd_len       = cmd_len_q;
    assign bus.wr_fifo_rd_en = wr_beat;
    assign bus.rd_fifo_wr_en = rd_beat;
    assign bus.busy          = (state != IDLE);
endmodule
